// File: rtl/stream_mac_pkg.sv
// Shared types and helpers for the pipelined stream multiply / multiply-accumulate.
package stream_mac_pkg;

   localparam int unsigned MAX_OP_W = 32;

   // One input beat; operands are held pre-extended to MAX_OP_W (operand widths up to 31)
   typedef struct packed {
      logic [MAX_OP_W-1:0] a;
      logic [MAX_OP_W-1:0] b;
      logic                acc;
      logic                last;
   } beat_t;

   function automatic int unsigned acc_width(input int unsigned wa, input int unsigned wb,
                                             input int unsigned guard);
      return wa + wb + guard;
   endfunction

   // Carry out for unsigned adds; same-sign addends yielding a different sign for signed adds
   function automatic logic add_overflow(input logic is_signed, input logic a_msb,
                                         input logic b_msb, input logic s_msb,
                                         input logic carry);
      if (is_signed) begin
         return (a_msb == b_msb) && (s_msb != a_msb);
      end
      return carry;
   endfunction

endpackage

// File: rtl/mac_pipe_stage.sv
// One pipeline register: valid bit plus payload, loaded on enable, cleared asynchronously.
module mac_pipe_stage #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (en) begin
         out_valid <= in_valid;
         out_data  <= in_data;
      end
   end

endmodule

// File: rtl/stream_mac_pipe.sv
// Pipelined valid/ready stream multiplier with per-beat grouped accumulation and overflow flag.
module stream_mac_pipe
   import stream_mac_pkg::*;
#(
   parameter  int unsigned WIDTH_A = 16,
   parameter  int unsigned WIDTH_B = 16,
   parameter  int unsigned GUARD   = 4,
   parameter  int unsigned LATENCY = 3,
   parameter  int unsigned SIGNED  = 0,
   localparam int unsigned ACC_W   = acc_width(WIDTH_A, WIDTH_B, GUARD)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_valid,
   output logic               i_ready,
   input  logic [WIDTH_A-1:0] i_payload_a,
   input  logic [WIDTH_B-1:0] i_payload_b,
   input  logic               i_payload_acc,
   input  logic               i_payload_last,
   output logic               o_valid,
   input  logic               o_ready,
   output logic [ACC_W-1:0]   o_payload,
   output logic               o_overflow
);

   localparam int unsigned PW = ACC_W + 2;

   logic advance;
   assign advance = !o_valid || o_ready;
   assign i_ready = advance;

   // Operand extension and product ahead of the first register
   logic       sign_a, sign_b;
   beat_t      in_beat;
   logic [ACC_W-1:0] a_x, b_x, prod;

   assign sign_a  = (SIGNED != 0) ? i_payload_a[WIDTH_A-1] : 1'b0;
   assign sign_b  = (SIGNED != 0) ? i_payload_b[WIDTH_B-1] : 1'b0;
   assign in_beat = '{a:    MAX_OP_W'($signed({sign_a, i_payload_a})),
                      b:    MAX_OP_W'($signed({sign_b, i_payload_b})),
                      acc:  i_payload_acc,
                      last: i_payload_last};
   assign a_x  = ACC_W'($signed(in_beat.a));
   assign b_x  = ACC_W'($signed(in_beat.b));
   assign prod = a_x * b_x;

   // Index 0 is the accepted beat itself; registers 1..LATENCY-1 are plain delay stages
   logic [LATENCY-1:0] stg_v;
   logic [PW-1:0]      stg_d [LATENCY];

   assign stg_v[0] = i_valid;
   assign stg_d[0] = {prod, in_beat.acc, in_beat.last};

   for (genvar g = 1; g < LATENCY; g++) begin : g_stage
      mac_pipe_stage #(.W(PW)) u_stage (
         .clk       (clk),
         .reset     (reset),
         .en        (advance),
         .in_valid  (stg_v[g-1]),
         .in_data   (stg_d[g-1]),
         .out_valid (stg_v[g]),
         .out_data  (stg_d[g])
      );
   end

   logic             f_valid, f_acc, f_last;
   logic [ACC_W-1:0] f_prod;
   logic [ACC_W-1:0] acc_q;
   logic             sticky_q;
   logic [ACC_W:0]   sum_c;
   logic             add_ovf;

   assign f_valid                = stg_v[LATENCY-1];
   assign {f_prod, f_acc, f_last} = stg_d[LATENCY-1];
   assign sum_c   = {1'b0, acc_q} + {1'b0, f_prod};
   assign add_ovf = add_overflow(SIGNED != 0, acc_q[ACC_W-1], f_prod[ACC_W-1],
                                 sum_c[ACC_W-1], sum_c[ACC_W]);

   logic             valid_n, ovf_n, sticky_n;
   logic [ACC_W-1:0] payload_n, acc_n;

   // Output / accumulate stage next-state
   always_comb begin
      valid_n   = o_valid;
      payload_n = o_payload;
      ovf_n     = o_overflow;
      acc_n     = acc_q;
      sticky_n  = sticky_q;
      if (advance) begin
         valid_n = 1'b0;
         if (f_valid) begin
            if (!f_acc) begin
               valid_n   = 1'b1;
               payload_n = f_prod;
               ovf_n     = 1'b0;
            end else if (!f_last) begin
               acc_n    = sum_c[ACC_W-1:0];
               sticky_n = sticky_q | add_ovf;
            end else begin
               valid_n   = 1'b1;
               payload_n = sum_c[ACC_W-1:0];
               ovf_n     = sticky_q | add_ovf;
               acc_n     = '0;
               sticky_n  = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_valid    <= 1'b0;
         o_payload  <= '0;
         o_overflow <= 1'b0;
         acc_q      <= '0;
         sticky_q   <= 1'b0;
      end else begin
         o_valid    <= valid_n;
         o_payload  <= payload_n;
         o_overflow <= ovf_n;
         acc_q      <= acc_n;
         sticky_q   <= sticky_n;
      end
   end

endmodule

// File: tb/tb_stream_mac_pipe.sv
// Self-checking bench: unsigned and signed instances fed the same stream, checked against a model.
module tb_stream_mac_pipe;

   localparam longint MOD  = 64'h0000_0010_0000_0000;
   localparam longint HALF = 64'h0000_0008_0000_0000;

   logic        clk, reset, i_valid, o_ready, acc, last;
   logic [15:0] a, b;
   logic        i_ready_u, o_valid_u, o_overflow_u;
   logic        i_ready_s, o_valid_s, o_overflow_s;
   logic [35:0] o_payload_u, o_payload_s;

   stream_mac_pipe #(.WIDTH_A(16), .WIDTH_B(16), .GUARD(4), .LATENCY(3), .SIGNED(0)) u_dut (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready_u),
      .i_payload_a(a), .i_payload_b(b), .i_payload_acc(acc), .i_payload_last(last),
      .o_valid(o_valid_u), .o_ready(o_ready), .o_payload(o_payload_u), .o_overflow(o_overflow_u));

   stream_mac_pipe #(.WIDTH_A(16), .WIDTH_B(16), .GUARD(4), .LATENCY(3), .SIGNED(1)) u_sdut (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready_s),
      .i_payload_a(a), .i_payload_b(b), .i_payload_acc(acc), .i_payload_last(last),
      .o_valid(o_valid_s), .o_ready(o_ready), .o_payload(o_payload_s), .o_overflow(o_overflow_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   // Reference model: true-integer group sums, overflow by range test
   typedef struct { logic [35:0] pay; logic ovf; } exp_t;
   exp_t   q_u[$];
   exp_t   q_s[$];
   longint m_acc [2];
   bit     m_sticky [2];

   function automatic void model_clear();
      for (int m = 0; m < 2; m++) begin
         m_acc[m]    = 0;
         m_sticky[m] = 1'b0;
      end
      q_u.delete();
      q_s.delete();
   endfunction

   function automatic void model_accept(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic macc, input logic mlast);
      for (int m = 0; m < 2; m++) begin
         longint pa, pb, p, t, v;
         bit     ov;
         exp_t   e;
         if (m == 1) begin
            pa = longint'($signed(ma));
            pb = longint'($signed(mb));
         end else begin
            pa = longint'(ma);
            pb = longint'(mb);
         end
         p = pa * pb;
         e.pay = 36'h0;
         e.ovf = 1'b0;
         if (!macc) begin
            e.pay = p[35:0];
            if (m == 0) q_u.push_back(e); else q_s.push_back(e);
         end else begin
            t  = m_acc[m] + p;
            ov = (m == 1) ? ((t >= HALF) || (t < -HALF)) : (t >= MOD);
            m_sticky[m] = m_sticky[m] | ov;
            if (mlast) begin
               e.pay = t[35:0];
               e.ovf = m_sticky[m];
               if (m == 0) q_u.push_back(e); else q_s.push_back(e);
               m_acc[m]    = 0;
               m_sticky[m] = 1'b0;
            end else begin
               v = t & (MOD - 1);
               if (m == 1 && v >= HALF) v = v - MOD;
               m_acc[m] = v;
            end
         end
      end
   endfunction

   // Scoreboard and hold-stability monitor, sampled mid-cycle
   bit          hold_u, hold_s, ho_u, ho_s;
   logic [35:0] hp_u, hp_s;
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         hold_u = 1'b0;
         hold_s = 1'b0;
      end else begin
         if (hold_u) begin
            check("hold_vld_u", o_valid_u, 1);
            check("hold_pay_u", o_payload_u, hp_u);
            check("hold_ovf_u", o_overflow_u, ho_u);
         end
         if (hold_s) begin
            check("hold_vld_s", o_valid_s, 1);
            check("hold_pay_s", o_payload_s, hp_s);
            check("hold_ovf_s", o_overflow_s, ho_s);
         end
         if (o_valid_u && o_ready) begin
            if (q_u.size() == 0) check("extra_out_u", o_valid_u, 0);
            else begin
               e = q_u.pop_front();
               check("sb_pay_u", o_payload_u, e.pay);
               check("sb_ovf_u", o_overflow_u, e.ovf);
            end
         end
         if (o_valid_s && o_ready) begin
            if (q_s.size() == 0) check("extra_out_s", o_valid_s, 0);
            else begin
               e = q_s.pop_front();
               check("sb_pay_s", o_payload_s, e.pay);
               check("sb_ovf_s", o_overflow_s, e.ovf);
            end
         end
         if (i_valid && i_ready_u) model_accept(a, b, acc, last);
         hold_u = o_valid_u && !o_ready;
         hold_s = o_valid_s && !o_ready;
         hp_u = o_payload_u;
         ho_u = o_overflow_u;
         hp_s = o_payload_s;
         ho_s = o_overflow_s;
      end
   end

   task automatic cyc();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tacc,
                       input logic tlast);
      bit done;
      int n;
      a = ta; b = tb; acc = tacc; last = tlast; i_valid = 1'b1;
      done = 1'b0;
      n = 0;
      while (!done) begin
         @(negedge clk);
         done = i_ready_u;
         n++;
         @(posedge clk);
         #1;
         if (!done && n > 50) begin
            check("send_timeout", i_ready_u, 1);
            done = 1'b1;
         end
      end
      i_valid = 1'b0;
   endtask

   // Returns at the first negedge showing o_valid (bounded)
   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!o_valid_u && lat < 20);
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [35:0] exp_u;
      logic [35:0] exp_s;
   } vec_t;
   vec_t tbl [7];

   initial begin
      int lat, nv, sent;
      logic [35:0] gp;
      logic go;
      logic [35:0] got[$];

      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int lat, nv, sent;
      logic [35:0] gp;
      logic go;
      logic [35:0] got[$];

      tbl[0] = '{16'd3,    16'd5,    36'd15,          36'd15};
      tbl[1] = '{16'hFFFF, 16'd2,    36'h0_0001_FFFE, 36'hF_FFFF_FFFE};
      tbl[2] = '{16'd0,    16'hFFFF, 36'h0,           36'h0};
      tbl[3] = '{16'hFFFF, 16'hFFFF, 36'h0_FFFE_0001, 36'h0_0000_0001};
      tbl[4] = '{16'h8000, 16'h8000, 36'h0_4000_0000, 36'h0_4000_0000};
      tbl[5] = '{16'h7FFF, 16'h8000, 36'h0_3FFF_8000, 36'hF_C000_8000};
      tbl[6] = '{16'd1,    16'd1,    36'd1,           36'd1};

      reset = 1'b1; i_valid = 1'b0; o_ready = 1'b1; acc = 1'b0; last = 1'b0;
      a = '0; b = '0;
      model_clear();
      #2 reset = 1'b0;
      @(negedge clk);
      check("rst_vld_u", o_valid_u, 0);
      check("rst_pay_u", o_payload_u, 0);
      check("rst_ovf_u", o_overflow_u, 0);
      check("rst_vld_s", o_valid_s, 0);
      check("rst_pay_s", o_payload_s, 0);
      check("rst_ovf_s", o_overflow_s, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("rst_rdy", i_ready_u, 1);
      @(posedge clk);
      #1;

      // Single beats: latency, product, signed/unsigned extension
      for (int i = 0; i < 7; i++) begin
         send(tbl[i].a, tbl[i].b, 1'b0, 1'b0);
         wait_out(lat);
         check($sformatf("tbl%0d_lat", i), lat, 3);
         check($sformatf("tbl%0d_vld_s", i), o_valid_s, 1);
         check($sformatf("tbl%0d_pay_u", i), o_payload_u, tbl[i].exp_u);
         check($sformatf("tbl%0d_pay_s", i), o_payload_s, tbl[i].exp_s);
         check($sformatf("tbl%0d_ovf_u", i), o_overflow_u, 0);
         @(posedge clk);
         #1;
         @(negedge clk);
         check($sformatf("tbl%0d_vld_after", i), o_valid_u, 0);
         @(posedge clk);
         #1;
      end

      // Back-to-back stream with sink stall on cycles 4..7
      sent = 0;
      for (int c = 0; c < 20; c++) begin
         o_ready = !(c >= 4 && c <= 7);
         if (sent < 8) begin
            i_valid = 1'b1; a = 16'(sent); b = 16'(sent + 1); acc = 1'b0; last = 1'b0;
         end else begin
            i_valid = 1'b0;
         end
         @(negedge clk);
         if (c < 12) check($sformatf("stall_rdy_c%0d", c), i_ready_u, (c >= 4 && c <= 7) ? 0 : 1);
         if (i_valid && i_ready_u) sent++;
         if (o_valid_u && o_ready) got.push_back(o_payload_u);
         @(posedge clk);
         #1;
      end
      i_valid = 1'b0;
      o_ready = 1'b1;
      check("stream_count", got.size(), 8);
      for (int k = 0; k < got.size(); k++) check($sformatf("stream_%0d", k), got[k], k * (k + 1));

      // Three-beat group: one output only
      send(16'd2, 16'd3, 1'b1, 1'b0);
      send(16'd4, 16'd5, 1'b1, 1'b0);
      send(16'd1, 16'd1, 1'b1, 1'b1);
      nv = 0; gp = '0; go = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         if (o_valid_u) begin
            nv++;
            gp = o_payload_u;
            go = o_overflow_u;
         end
         @(posedge clk);
         #1;
      end
      check("grp_count", nv, 1);
      check("grp_pay", gp, 27);
      check("grp_ovf", go, 0);

      // Unsigned overflow across a 17-beat group, then a clean single beat
      for (int k = 0; k < 17; k++) send(16'hFFFF, 16'hFFFF, 1'b1, k == 16);
      wait_out(lat);
      check("ovf17_lat", lat, 3);
      check("ovf17_pay_u", o_payload_u, 36'h0_FFDE_0011);
      check("ovf17_ovf_u", o_overflow_u, 1);
      check("ovf17_pay_s", o_payload_s, 36'd17);
      check("ovf17_ovf_s", o_overflow_s, 0);
      @(posedge clk);
      #1;
      send(16'd1, 16'd1, 1'b0, 1'b0);
      wait_out(lat);
      check("post_ovf_pay", o_payload_u, 1);
      check("post_ovf_ovf", o_overflow_u, 0);
      @(posedge clk);
      #1;

      // Signed sum reaching exactly 2^35: overflow for signed only
      for (int k = 0; k < 32; k++) send(16'h8000, 16'h8000, 1'b1, k == 31);
      wait_out(lat);
      check("sovf_pay_u", o_payload_u, 36'h8_0000_0000);
      check("sovf_ovf_u", o_overflow_u, 0);
      check("sovf_pay_s", o_payload_s, 36'h8_0000_0000);
      check("sovf_ovf_s", o_overflow_s, 1);
      @(posedge clk);
      #1;

      // Async reset mid-group while an output is being held
      send(16'd2, 16'd3, 1'b1, 1'b0);
      send(16'd4, 16'd5, 1'b1, 1'b0);
      send(16'd7, 16'd7, 1'b0, 1'b0);
      o_ready = 1'b0;
      wait_out(lat);
      check("pre_rst_vld", o_valid_u, 1);
      @(posedge clk);
      #3 reset = 1'b0;
      model_clear();
      #1;
      check("mid_rst_vld_u", o_valid_u, 0);
      check("mid_rst_vld_s", o_valid_s, 0);
      check("mid_rst_pay", o_payload_u, 0);
      cyc();
      cyc();
      reset = 1'b1;
      o_ready = 1'b1;
      send(16'd3, 16'd5, 1'b0, 1'b0);
      wait_out(lat);
      check("rst_single_lat", lat, 3);
      check("rst_single_pay", o_payload_u, 15);
      check("rst_single_ovf", o_overflow_u, 0);
      @(posedge clk);
      #1;
      send(16'd3, 16'd5, 1'b1, 1'b1);
      wait_out(lat);
      check("rst_group_pay", o_payload_u, 15);
      check("rst_group_ovf", o_overflow_u, 0);
      @(posedge clk);
      #1;

      // Random traffic with random sink backpressure
      for (int r = 0; r < 500; r++) begin
         i_valid = ($urandom_range(3) != 0);
         a       = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
         b       = ($urandom_range(3) == 0) ? 16'h8000 : 16'($urandom);
         acc     = 1'($urandom_range(1));
         last    = ($urandom_range(3) == 0);
         o_ready = ($urandom_range(3) != 0);
         cyc();
      end
      i_valid = 1'b0;
      o_ready = 1'b1;
      repeat (10) cyc();
      check("drain_u", q_u.size(), 0);
      check("drain_s", q_s.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
